// File: rtl/nibble_serial_alu_seq_if.sv
// Request/response bundle between a controller and the nibble-serial add/sub sequencer.
interface nibble_serial_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_alu_seq.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single shared 4-bit adder slice.
module fulladd4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

module nibble_serial_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_alu_seq_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int SW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NIB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [SW-1:0]    step_q;
    logic             carry_q, cout_q, ovf_q;
    logic [3:0]       sum_nib;
    logic             c_nib;
    logic             accept;
    logic             last_step;

    // Operands shift right each step, so the adder always sees the low nibble.
    fulladd4 u_add (
        .a_i (a_q[3:0]),
        .b_i (b_q[3:0]),
        .c_i (carry_q),
        .s_o (sum_nib),
        .c_o (c_nib)
    );

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_step = (step_q == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // B is stored already inverted for subtract; the carry-in of 1 completes the two's complement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            step_q   <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.op_sub ? ~bus.b : bus.b;
            result_q <= '0;
            step_q   <= '0;
            carry_q  <= bus.op_sub;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state_q == S_RUN) begin
            result_q[{step_q, 2'b00} +: 4] <= sum_nib;
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            carry_q <= c_nib;
            step_q  <= step_q + 1'b1;
            if (last_step) begin
                cout_q <= c_nib;
                ovf_q  <= (a_q[3] == b_q[3]) && (sum_nib[3] != a_q[3]);
            end
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Scoreboard bench for the nibble-serial sequencer at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_alu_seq_if #(.WIDTH(16)) if16 ();
    nibble_serial_alu_seq_if #(.WIDTH(4))  if4 ();

    nibble_serial_alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    nibble_serial_alu_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   next_ok16 = 0, next_ok4 = 0;
    logic held16 = 1'b0, held4 = 1'b0;
    exp_t last16, last4;
    logic prev_done16 = 1'b0, prev_done4 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference via plain integer arithmetic: unsigned sum for carry, signed range for overflow.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input int due);
        exp_t   e;
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & m;
        longint ub   = longint'(b) & m;
        longint full, sa, sb, sr;
        full   = sub ? (ua + ((~ub) & m) + 1) : (ua + ub);
        e.res  = 16'(full & m);
        e.cout = ((full >> w) & 1) != 0;
        sa     = (ua >= half) ? ua - (m + 1) : ua;
        sb     = (ub >= half) ? ub - (m + 1) : ub;
        sr     = sub ? (sa - sb) : (sa + sb);
        e.ovf  = (sr < -half) || (sr >= half);
        e.due  = due;
        return e;
    endfunction

    task automatic drive16(input logic st, input logic [15:0] a, input logic [15:0] b, input logic sub);
        @(posedge clk);
        #1;
        check("busy16", 32'(if16.busy), 32'(cyc < next_ok16));
        if (held16 && cyc >= next_ok16) begin
            check("held_result16", 32'(if16.result), 32'(last16.res));
            check("held_cout16", 32'(if16.cout), 32'(last16.cout));
        end
        if16.start = st; if16.a = a; if16.b = b; if16.op_sub = sub;
        if (st && cyc >= next_ok16) begin
            q16.push_back(model(16, a, b, sub, cyc + 5));
            next_ok16 = cyc + 6;
        end
    endtask

    task automatic drive4(input logic st, input logic [3:0] a, input logic [3:0] b, input logic sub);
        @(posedge clk);
        #1;
        check("busy4", 32'(if4.busy), 32'(cyc < next_ok4));
        if (held4 && cyc >= next_ok4)
            check("held_result4", 32'(if4.result), 32'(last4.res[3:0]));
        if4.start = st; if4.a = a; if4.b = b; if4.op_sub = sub;
        if (st && cyc >= next_ok4) begin
            q4.push_back(model(4, 16'(a), 16'(b), sub, cyc + 2));
            next_ok4 = cyc + 3;
        end
    endtask

    task automatic wait16();
        int n = 0;
        while (q16.size() != 0 && n < 20) begin
            drive16(1'b0, 16'h0, 16'h0, 1'b0);
            n++;
        end
        check("drain16", 32'(q16.size()), 32'd0);
    endtask

    task automatic wait4();
        int n = 0;
        while (q4.size() != 0 && n < 20) begin
            drive4(1'b0, 4'h0, 4'h0, 1'b0);
            n++;
        end
        check("drain4", 32'(q4.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if16.done) begin
                exp_t e;
                check("done_pulse16", 32'(prev_done16), 32'd0);
                check("done_expected16", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("latency16", 32'(cyc), 32'(e.due));
                    check("result16", 32'(if16.result), 32'(e.res));
                    check("cout16", 32'(if16.cout), 32'(e.cout));
                    check("ovf16", 32'(if16.ovf), 32'(e.ovf));
                    $display("w16 done cyc=%0d result=%h cout=%0b ovf=%0b", cyc, if16.result, if16.cout, if16.ovf);
                    last16 = e;
                    held16 = 1'b1;
                end
            end
            if (if4.done) begin
                exp_t e;
                check("done_pulse4", 32'(prev_done4), 32'd0);
                check("done_expected4", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("latency4", 32'(cyc), 32'(e.due));
                    check("result4", 32'(if4.result), 32'(e.res[3:0]));
                    check("cout4", 32'(if4.cout), 32'(e.cout));
                    check("ovf4", 32'(if4.ovf), 32'(e.ovf));
                    $display("w4  done cyc=%0d result=%h cout=%0b ovf=%0b", cyc, if4.result, if4.cout, if4.ovf);
                    last4 = e;
                    held4 = 1'b1;
                end
            end
            prev_done16 = if16.done;
            prev_done4  = if4.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
        logic [15:0] tb [6] = '{16'h0FCD, 16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  sa [6] = '{4'hF, 4'h5, 4'h7, 4'h7, 4'h8, 4'h3};
        logic [3:0]  sb [6] = '{4'h1, 4'h7, 4'h5, 4'h1, 4'h1, 4'h4};
        logic        ss [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        if16.start = 1'b0; if16.op_sub = 1'b0; if16.a = '0; if16.b = '0;
        if4.start  = 1'b0; if4.op_sub  = 1'b0; if4.a  = '0; if4.b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy16", 32'(if16.busy), 32'd0);
        check("rst_done16", 32'(if16.done), 32'd0);
        check("rst_result16", 32'(if16.result), 32'd0);
        check("rst_cout16", 32'(if16.cout), 32'd0);
        check("rst_ovf16", 32'(if16.ovf), 32'd0);
        check("rst_busy4", 32'(if4.busy), 32'd0);
        check("rst_result4", 32'(if4.result), 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive16(1'b1, ta[i], tb[i], ts[i]);
            wait16();
        end
        for (int i = 0; i < 6; i++) begin
            drive16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            wait16();
        end

        // start held high across two full operations with operands changing every cycle
        for (int i = 0; i < 14; i++)
            drive16(1'b1, 16'(16'h1111 * i), 16'(16'h0F0F + i), 1'(i % 2));
        wait16();

        drive16(1'b1, 16'h1234, 16'h0FCD, 1'b0);
        repeat (3) drive16(1'b0, 16'h0, 16'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy16", 32'(if16.busy), 32'd0);
        check("abort_done16", 32'(if16.done), 32'd0);
        check("abort_result16", 32'(if16.result), 32'd0);
        check("abort_cout16", 32'(if16.cout), 32'd0);
        check("abort_ovf16", 32'(if16.ovf), 32'd0);
        q16.delete();
        next_ok16 = 0;
        held16 = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        drive16(1'b1, 16'h0001, 16'h0001, 1'b0);
        wait16();

        for (int i = 0; i < 6; i++) begin
            drive4(1'b1, sa[i], sb[i], ss[i]);
            wait4();
        end
        for (int i = 0; i < 8; i++)
            drive4(1'b1, 4'(i), 4'(15 - i), 1'(i % 2));
        wait4();

        repeat (3) drive16(1'b0, 16'h0, 16'h0, 1'b0);
        check("pending16", 32'(q16.size()), 32'd0);
        check("pending4", 32'(q4.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
